// File: rtl/motor_ramp_if.sv
// Switch inputs and L298 bridge outputs of the motor ramp sequencer.
interface motor_ramp_if;
  logic [7:0] sw;
  logic       dir_fwd;
  logic       dir_rev;
  logic       pwm_out;
  logic [3:0] duty_now;
  logic [1:0] state;
  logic       busy;

  modport master (
    output sw,
    input  dir_fwd, dir_rev, pwm_out, duty_now, state, busy
  );

  modport slave (
    input  sw,
    output dir_fwd, dir_rev, pwm_out, duty_now, state, busy
  );
endinterface

// File: rtl/motor_ramp_sequencer.sv
// L298 channel sequencer: switch decode, duty ramp, reversal dead-time, PWM.
// MOTOR_DEAD_BRAKE_EN: fast-brake (dir 11, pwm high) during dead-time.
module motor_ramp_sequencer #(
  parameter int PWM_PERIOD  = 10,
  parameter int RAMP_DIV    = 1_000_000,
  parameter int DEAD_CYCLES = 5_000_000
) (
  input logic        clk,
  input logic        rst,
  motor_ramp_if.slave bus
);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int CW = (PW > 4) ? PW : 4;
`ifdef MOTOR_DEAD_BRAKE_EN
  localparam logic BRAKE = 1'b1;
`else
  localparam logic BRAKE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    DEAD = 2'd3
  } state_t;

  state_t          st_q, st_d;
  logic [3:0]      tgt_duty;
  logic            tgt_rev;
  logic [RW-1:0]   ramp_cnt;
  logic            tick;
  logic [3:0]      duty_q, duty_d;
  logic            rev_q, rev_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic [PW-1:0]   pwm_cnt;
  logic [3:0]      shadow;
  logic            pwm_q;
  logic            pwm_cmp;
  logic [1:0]      dir;

  // Highest switch index wins; no switch keeps the last direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_duty <= '0;
      tgt_rev  <= 1'b0;
    end else begin
      priority case (1'b1)
        bus.sw[7]: begin tgt_duty <= 4'd3;  tgt_rev <= 1'b1; end
        bus.sw[6]: begin tgt_duty <= 4'd5;  tgt_rev <= 1'b1; end
        bus.sw[5]: begin tgt_duty <= 4'd7;  tgt_rev <= 1'b1; end
        bus.sw[4]: begin tgt_duty <= 4'd10; tgt_rev <= 1'b1; end
        bus.sw[3]: begin tgt_duty <= 4'd3;  tgt_rev <= 1'b0; end
        bus.sw[2]: begin tgt_duty <= 4'd5;  tgt_rev <= 1'b0; end
        bus.sw[1]: begin tgt_duty <= 4'd7;  tgt_rev <= 1'b0; end
        bus.sw[0]: begin tgt_duty <= 4'd10; tgt_rev <= 1'b0; end
        default:   tgt_duty <= 4'd0;
      endcase
    end
  end

  assign tick = (ramp_cnt == RW'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ramp_cnt <= '0;
    else     ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      duty_q <= '0;
      rev_q  <= 1'b0;
      dead_q <= '0;
    end else begin
      st_q   <= st_d;
      duty_q <= duty_d;
      rev_q  <= rev_d;
      dead_q <= dead_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    duty_d = duty_q;
    rev_d  = rev_q;
    dead_d = dead_q;
    unique case (st_q)
      IDLE: begin
        duty_d = '0;
        if (tgt_duty != 4'd0) begin
          st_d  = RUN;
          rev_d = tgt_rev;
        end
      end
      RUN: begin
        if (tgt_duty != 4'd0 && tgt_rev != rev_q) begin
          st_d = STOP;
        end else if (tgt_duty == 4'd0 && duty_q == 4'd0) begin
          st_d = IDLE;
        end else if (tick) begin
          if (duty_q < tgt_duty)      duty_d = duty_q + 4'd1;
          else if (duty_q > tgt_duty) duty_d = duty_q - 4'd1;
        end
      end
      STOP: begin
        if (duty_q == 4'd0) begin
          st_d   = DEAD;
          dead_d = '0;
        end else if (tick) begin
          duty_d = duty_q - 4'd1;
        end
      end
      DEAD: begin
        duty_d = '0;
        // Switch state is sampled only here, at the end of the dead-time.
        if (dead_q == DW'(DEAD_CYCLES - 1)) begin
          dead_d = '0;
          rev_d  = tgt_rev;
          st_d   = (tgt_duty != 4'd0) ? RUN : IDLE;
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    dir = 2'b00;
    unique case (st_q)
      RUN, STOP: dir = {~rev_q, rev_q};
      DEAD:      dir = {BRAKE, BRAKE};
      default:   dir = 2'b00;
    endcase
  end

  assign pwm_cmp = CW'(pwm_cnt) < CW'(shadow);

  // Forcing on the next state keeps the pwm pin aligned with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
        pwm_cnt <= '0;
        shadow  <= duty_q;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      pwm_q <= (st_d == DEAD) ? BRAKE : pwm_cmp;
    end
  end

  assign bus.dir_fwd  = dir[1];
  assign bus.dir_rev  = dir[0];
  assign bus.pwm_out  = pwm_q;
  assign bus.duty_now = duty_q;
  assign bus.state    = st_q;
  assign bus.busy     = (st_q == STOP) || (st_q == DEAD);
endmodule
